// File: rtl/elevator_pkg.sv
// Shared constants for the elevator scheduler and car mover: state encoding,
// travel direction and floor-mask helpers.
package elevator_pkg;

    localparam int FLOORS     = 4;
    localparam int DOOR_TICKS = 4;
    localparam int TW         = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DOOR = 2'd1;
    localparam logic [1:0] S_MOVE = 2'd2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef logic [FLOORS-1:0] floor_vec_t;

    // Floors strictly above pos.
    function automatic floor_vec_t above_mask(input logic [1:0] pos);
        return floor_vec_t'(4'b1110 << pos);
    endfunction

    // Floors strictly below pos.
    function automatic floor_vec_t below_mask(input logic [1:0] pos);
        return floor_vec_t'(~(4'b1111 << pos));
    endfunction

endpackage

// File: rtl/elevator_scheduler_req_latch_bank.sv
// Pending-request latches (car, hall-up, hall-down) with service clearing and
// the ahead/behind reductions relative to the car position and direction.
module req_latch_bank
    import elevator_pkg::*;
(
    input  logic              clk_1hz,
    input  logic              rst,
    input  logic [FLOORS-1:0] car_btn,
    input  logic [FLOORS-1:0] up_btn,
    input  logic [FLOORS-1:0] dn_btn,
    input  logic [1:0]        position,
    input  logic              dir,
    input  logic              absorb,
    input  logic              serve,
    output logic [FLOORS-1:0] req_car,
    output logic [FLOORS-1:0] req_up,
    output logic [FLOORS-1:0] req_dn,
    output logic              any_above,
    output logic              any_below,
    output logic              ahead,
    output logic              behind
);

    logic [FLOORS-1:0] req_car_r, req_up_r, req_dn_r;
    logic [FLOORS-1:0] here_s, all_s;
    logic [FLOORS-1:0] set_car_s, set_up_s, set_dn_s;
    logic [FLOORS-1:0] clr_car_s, clr_up_s, clr_dn_s;
    logic [FLOORS-1:0] keep_s;

    // Reductions plus set/clear masks; a reversal at service also drops the opposite hall call.
    always_comb begin
        here_s    = 4'b0001 << position;
        all_s     = req_car_r | req_up_r | req_dn_r;
        any_above = |(all_s & above_mask(position));
        any_below = |(all_s & below_mask(position));
        ahead     = dir ? any_above : any_below;
        behind    = dir ? any_below : any_above;
        keep_s    = absorb ? ~here_s : 4'b1111;
        set_car_s = car_btn & keep_s;
        set_up_s  = up_btn & 4'b0111 & keep_s;
        set_dn_s  = dn_btn & 4'b1110 & keep_s;
        clr_car_s = serve ? here_s : 4'b0000;
        clr_up_s  = (serve && (dir || !ahead)) ? here_s : 4'b0000;
        clr_dn_s  = (serve && (!dir || !ahead)) ? here_s : 4'b0000;
    end

    // Latch update: a press in the same cycle as a clear wins.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            req_car_r <= 4'b0000;
            req_up_r  <= 4'b0000;
            req_dn_r  <= 4'b0000;
        end else begin
            req_car_r <= (req_car_r & ~clr_car_s) | set_car_s;
            req_up_r  <= (req_up_r & ~clr_up_s) | set_up_s;
            req_dn_r  <= (req_dn_r & ~clr_dn_s) | set_dn_s;
        end
    end

    assign req_car = req_car_r;
    assign req_up  = req_up_r;
    assign req_dn  = req_dn_r;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler for the 4-floor car mover: FSM, door dwell timer and
// mover/lamp output decode.
module elevator_scheduler
    import elevator_pkg::*;
(
    input  logic              clk_1hz,
    input  logic              rst,
    input  logic [FLOORS-1:0] car_btn,
    input  logic [FLOORS-1:0] up_btn,
    input  logic [FLOORS-1:0] dn_btn,
    input  logic              door_hold,
    input  logic [1:0]        position,
    output logic              stop,
    output logic              head,
    output logic              DoorClose,
    output logic [FLOORS-1:0] req_lamp,
    output logic              busy
);

    localparam logic [TW-1:0] T_LOAD = TW'(DOOR_TICKS - 1);
    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    logic [1:0]        state_r, state_nxt_s;
    logic              dir_r, dir_nxt_s;
    logic [TW-1:0]     timer_r, timer_nxt_s;
    logic              serve_s, absorb_s, reload_s;
    logic              here_s, hit_s, press_here_s;
    logic [FLOORS-1:0] req_car_s, req_up_s, req_dn_s;
    logic              any_above_s, any_below_s, ahead_s, behind_s;

    req_latch_bank u_bank (
        .clk_1hz   (clk_1hz),
        .rst       (rst),
        .car_btn   (car_btn),
        .up_btn    (up_btn),
        .dn_btn    (dn_btn),
        .position  (position),
        .dir       (dir_r),
        .absorb    (absorb_s),
        .serve     (serve_s),
        .req_car   (req_car_s),
        .req_up    (req_up_s),
        .req_dn    (req_dn_s),
        .any_above (any_above_s),
        .any_below (any_below_s),
        .ahead     (ahead_s),
        .behind    (behind_s)
    );

    // Next-state logic; service happens on the same edge that enters DOOR.
    always_comb begin
        here_s       = req_car_s[position] | req_up_s[position] | req_dn_s[position];
        hit_s        = req_car_s[position]
                     | (dir_r ? req_up_s[position] : req_dn_s[position])
                     | (!ahead_s & (req_up_s[position] | req_dn_s[position]));
        press_here_s = car_btn[position]
                     | (up_btn[position] & (position != 2'd3))
                     | (dn_btn[position] & (position != 2'd0));
        absorb_s     = (state_r == S_DOOR);
        reload_s     = absorb_s & (door_hold | press_here_s);
        state_nxt_s  = state_r;
        dir_nxt_s    = dir_r;
        timer_nxt_s  = timer_r;
        serve_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (here_s) begin
                    serve_s     = 1'b1;
                    state_nxt_s = S_DOOR;
                    timer_nxt_s = T_LOAD;
                    dir_nxt_s   = ahead_s ? dir_r : ~dir_r;
                end else if (any_above_s) begin
                    dir_nxt_s   = DIR_UP;
                    state_nxt_s = S_MOVE;
                end else if (any_below_s) begin
                    dir_nxt_s   = DIR_DN;
                    state_nxt_s = S_MOVE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DOOR: begin
                if (reload_s) begin
                    timer_nxt_s = T_LOAD;
                end else if (timer_r != T_ZERO) begin
                    timer_nxt_s = timer_r - T_ONE;
                end else if (ahead_s) begin
                    state_nxt_s = S_MOVE;
                end else if (behind_s) begin
                    dir_nxt_s   = ~dir_r;
                    state_nxt_s = S_MOVE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MOVE: begin
                if (hit_s) begin
                    serve_s     = 1'b1;
                    state_nxt_s = S_DOOR;
                    timer_nxt_s = T_LOAD;
                    dir_nxt_s   = ahead_s ? dir_r : ~dir_r;
                end else begin
                    state_nxt_s = S_MOVE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // FSM, direction and dwell timer registers.
    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            dir_r   <= DIR_UP;
            timer_r <= T_ZERO;
        end else begin
            state_r <= state_nxt_s;
            dir_r   <= dir_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // stop must follow position combinationally so the mover halts before its next step.
    assign stop      = (state_r == S_MOVE) ? hit_s : 1'b1;
    assign head      = dir_r;
    assign DoorClose = (state_r == S_MOVE);
    assign busy      = (state_r != S_IDLE);
    assign req_lamp  = req_car_s | req_up_s | req_dn_s;

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Request scheduler for the 4-floor elevator car mover. It latches hall-call and in-car floor requests, and runs a SCAN (collective) policy: keep travelling in one direction while requests lie ahead, then reverse. It drives the mover's stop, head and DoorClose inputs and reads back its position. It also times the door-open dwell and provides the request lamps.

Parameters:
FLOORS, 4, number of floors; fixed at 4 so floor indices match the 2-bit position.
DOOR_TICKS, 4, clk_1hz cycles the door stays open at a served floor.
TW, 3, width of the dwell counter; must satisfy 2^TW > DOOR_TICKS.

Ports:
clk_1hz  in  1  system tick clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
car_btn  in  4  in-car floor buttons, one per floor, level-sensitive.
up_btn  in  4  hall up-call buttons; bit 3 is ignored.
dn_btn  in  4  hall down-call buttons; bit 0 is ignored.
door_hold  in  1  door-open button; extends the dwell.
position  in  2  current floor reported by the car mover.
stop  out  1  to mover; 1 = do not travel (door open).
head  out  1  to mover; 1 = up, 0 = down (registered direction).
DoorClose  out  1  to mover; 1 = door may close and car may travel.
req_lamp  out  4  OR of all pending requests per floor.
busy  out  1  1 when state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, dir=1, all request latches=0, timer=0. Resulting outputs: stop=1, head=1, DoorClose=0, req_lamp=0, busy=0.
- Request latches: req_car[3:0], req_up[2:0], req_dn[3:1].
  - Set on any clock where the matching button is 1.
  - Cleared only by service (see below).
  - If set and clear hit the same bit in the same cycle, set wins, except at the floor currently being served while in DOOR. There the press is absorbed and the timer reloads.
- Helper terms:
  - ahead = any request at a floor strictly above position (dir=1) or strictly below it (dir=0).
  - behind = the same test in the opposite direction.
  - hit(p) = req_car[p] | (dir ? req_up[p] : req_dn[p]) | (!ahead & (req_up[p] | req_dn[p])).
- States: IDLE, DOOR, MOVE. Encoding constants live in the package.
- IDLE:
  - Outputs stop=1, DoorClose=0.
  - If any request at position: go to DOOR and perform service.
  - Else if any request above: dir=1, go to MOVE.
  - Else if any request below: dir=0, go to MOVE.
  - Else stay in IDLE.
- DOOR:
  - Outputs stop=1, DoorClose=0.
  - Timer decrements each cycle.
  - door_hold=1, or a new press at the current floor, reloads timer to DOOR_TICKS-1.
  - When timer==0 and no reload is pending:
    - if ahead: go to MOVE;
    - else if behind: toggle dir, go to MOVE;
    - else go to IDLE.
- MOVE:
  - DoorClose=1.
  - stop is combinational: stop = hit(position), so the mover sees the stop before its next step.
  - On hit(position): go to DOOR and perform service.
- Service at floor p (same edge as entry to DOOR):
  - Clear req_car[p], plus req_up[p] if dir=1 or req_dn[p] if dir=0.
  - If !ahead: toggle dir and also clear the opposite hall call at p.
  - Load timer = DOOR_TICKS-1.
- Boundaries:
  - Floor 3 with dir=1: ahead is always 0, so the car reverses there; the same holds at floor 0 with dir=0.
  - A request for the car's own floor while in MOVE is served only when position equals that floor.
- head mirrors dir and changes only on IDLE→MOVE, DOOR→MOVE and reversal edges, never mid-travel.
- rst asserted mid-MOVE or mid-DOOR: the block returns immediately to IDLE and all pending requests are discarded.
- Latency: button press to lamp = 1 cycle. IDLE with a request at another floor to DoorClose=1 = 1 cycle.

Decomposition:
- Package elevator_pkg holds: the state encoding (S_IDLE, S_DOOR, S_MOVE), the DIR_UP and DIR_DN constants, and the FLOORS constant shared with the mover.
- One sub-module, req_latch_bank: the set/clear latch array plus the ahead/behind reduction, taking position and dir as inputs.
- The top level keeps the FSM, the timer and the output decode.

Test Plan:
- Reset then idle: rst pulse with no buttons → stop=1, DoorClose=0, head=1, busy=0, req_lamp=0000.
- Single car call: position=0, car_btn[2] for 1 cycle → req_lamp=0100; next cycle MOVE with DoorClose=1, head=1. When position becomes 2: stop=1 in the same cycle, DOOR, lamp clears. After DOOR_TICKS cycles: IDLE.
- Direction filtering: car at 0 heading up with car_btn[3] and dn_btn[1] pending → no stop at 1 on the way up. Stop at 3, then reverse (head=0) and stop at 1.
- Door hold: in DOOR, hold door_hold=1 for 6 cycles → stop stays 1 throughout; dwell ends DOOR_TICKS cycles after release.
- Top-floor reversal: car moving up, up_btn and car_btn empty above, dn_btn[3] pending → stop at 3, dir flips to 0, req_dn[3] cleared.
- Async reset mid-travel: assert rst while in MOVE with 3 lamps lit → immediately state=IDLE, req_lamp=0000, stop=1, without waiting for a clock edge.
